// File: rtl/ssd_segment_decoder.sv
// -----------------------------------------------------------------------------
// ssd_segment_decoder
//
// Receive-side decoder for a multiplexed 2-digit seven-segment bus. It samples
// {digit_select, segments}, accepts a pattern only after STABLE_CYCLES identical
// consecutive samples, and decodes the pattern to a 4-bit code. A low digit and
// then a high digit are assembled into an 8-bit {hi, lo} word, which is offered
// on a valid/ready output.
//
// Handshake: out_valid rises with the word and stays high, with out_value and
// out_err frozen, until the cycle where out_valid & out_ready is seen on a
// rising edge. out_ready has no effect while out_valid is low.
//
// Ports
//   clk           in   1  system clock, rising edge
//   reset         in   1  synchronous, active-high reset
//   segments      in   7  {a,b,c,d,e,f,g}, a = bit 6
//   digit_select  in   1  0 = low (ones) digit, 1 = high (tens) digit
//   out_value     out  8  {hi_code, lo_code}
//   out_err       out  1  a nibble came from an unrecognised pattern
//   out_valid     out  1  word valid, held until accepted
//   out_ready     in   1  consumer accept
//   overrun       out  1  sticky: a capture was dropped while out_valid was high
//   dbg_state     out  2  current FSM state (S_LO / S_HI / S_OUT)
//
// Build option
//   SSD_ACTIVE_LOW_EN : when defined, segments is inverted on the way into the
//                       sample register (common-anode bus, 0 = lit).
// -----------------------------------------------------------------------------
module ssd_segment_decoder #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] segments,
  input  logic       digit_select,
  output logic [7:0] out_value,
  output logic       out_err,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       overrun,
  output logic [1:0] dbg_state
);

  localparam logic [1:0] S_LO  = 2'd0;
  localparam logic [1:0] S_HI  = 2'd1;
  localparam logic [1:0] S_OUT = 2'd2;

  localparam int CW = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);
  // Count value seen on the edge that completes STABLE_CYCLES identical samples.
  localparam logic [CW-1:0] CNT_HIT = CW'(STABLE_CYCLES - 2);

  logic [7:0]    w_sample;
  logic [7:0]    r_prev;
  logic [CW-1:0] r_cnt;
  logic          w_match;
  logic          w_capture;
  logic [3:0]    w_code;
  logic          w_code_err;

  logic [1:0]    r_state;
  logic [3:0]    r_lo_code;
  logic          r_lo_err;
  logic [7:0]    r_out_value;
  logic          r_out_err;
  logic          r_out_valid;
  logic          r_overrun;

`ifdef SSD_ACTIVE_LOW_EN
  assign w_sample = {digit_select, ~segments};
`else
  assign w_sample = {digit_select, segments};
`endif

  assign w_match = (w_sample == r_prev);
  // Fires once per stable window: the counter saturates past CNT_HIT, so a
  // further capture needs a change that clears it.
  assign w_capture = w_match && (r_cnt == CNT_HIT);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_prev <= '0;
      r_cnt  <= '0;
    end else begin
      r_prev <= w_sample;
      if (!w_match) begin
        r_cnt <= '0;
      end else if (r_cnt != CNT_MAX) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // On a capture edge r_prev holds the same pattern as the live sample, so
  // decoding the registered copy keeps the input pin off the decode path.
  always_comb begin
    w_code_err = 1'b0;
    case (r_prev[6:0])
      7'h7E:   w_code = 4'h0;
      7'h30:   w_code = 4'h1;
      7'h6D:   w_code = 4'h2;
      7'h79:   w_code = 4'h3;
      7'h33:   w_code = 4'h4;
      7'h5B:   w_code = 4'h5;
      7'h5F:   w_code = 4'h6;
      7'h72:   w_code = 4'h7;
      7'h7F:   w_code = 4'h8;
      7'h7B:   w_code = 4'h9;
      7'h00:   w_code = 4'hA;
      default: begin
        w_code     = 4'hF;
        w_code_err = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_LO;
      r_lo_code   <= '0;
      r_lo_err    <= 1'b0;
      r_out_value <= '0;
      r_out_err   <= 1'b0;
      r_out_valid <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      case (r_state)
        S_LO: begin
          if (w_capture && !r_prev[7]) begin
            r_lo_code <= w_code;
            r_lo_err  <= w_code_err;
            r_state   <= S_HI;
          end
        end
        S_HI: begin
          if (w_capture) begin
            if (r_prev[7]) begin
              r_out_value <= {w_code, r_lo_code};
              r_out_err   <= r_lo_err | w_code_err;
              r_out_valid <= 1'b1;
              r_state     <= S_OUT;
            end else begin
              // A newer low digit replaces the pending one.
              r_lo_code <= w_code;
              r_lo_err  <= w_code_err;
            end
          end
        end
        S_OUT: begin
          // Any capture here is dropped, even on the accepting edge.
          if (w_capture) begin
            r_overrun <= 1'b1;
          end
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_LO;
          end
        end
        default: begin
          r_state     <= S_LO;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign out_value = r_out_value;
  assign out_err   = r_out_err;
  assign out_valid = r_out_valid;
  assign overrun   = r_overrun;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_ssd_segment_decoder.sv
module tb_ssd_segment_decoder;

  logic       clk;
  logic       reset;
  logic [6:0] segments;
  logic       digit_select;
  logic [7:0] out_value;
  logic       out_err;
  logic       out_valid;
  logic       out_ready;
  logic       overrun;
  logic [1:0] dbg_state;

  int checks;
  int failures;

  ssd_segment_decoder #(.STABLE_CYCLES(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .segments     (segments),
    .digit_select (digit_select),
    .out_value    (out_value),
    .out_err      (out_err),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .overrun      (overrun),
    .dbg_state    (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] lo_pat;
    logic [6:0] hi_pat;
    logic [7:0] exp_value;
    logic       exp_err;
  } vec_t;

  vec_t vecs[8];

  // Patterns are written active-high; convert to the bus polarity in use.
  function automatic logic [6:0] enc(input logic [6:0] p);
`ifdef SSD_ACTIVE_LOW_EN
    return ~p;
`else
    return p;
`endif
  endfunction

  // driver tasks: inputs change 1 time unit after a rising edge, outputs are
  // sampled at the same point.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input logic ds, input logic [6:0] pat, input int n);
    digit_select = ds;
    segments     = enc(pat);
    step(n);
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    step(1);
    out_ready = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(2);
    reset = 1'b0;
  endtask

  // scoreboard
  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  initial begin
    vecs[0] = '{7'h5B, 7'h30, 8'h15, 1'b0};
    vecs[1] = '{7'h01, 7'h7F, 8'h8F, 1'b1};
    vecs[2] = '{7'h7E, 7'h00, 8'hA0, 1'b0};
    vecs[3] = '{7'h72, 7'h7B, 8'h97, 1'b0};
    vecs[4] = '{7'h33, 7'h5F, 8'h64, 1'b0};
    vecs[5] = '{7'h6D, 7'h79, 8'h32, 1'b0};
    vecs[6] = '{7'h00, 7'h7F, 8'h8A, 1'b0};
    vecs[7] = '{7'h7E, 7'h7C, 8'hF0, 1'b1};

    checks = 0;
    failures = 0;
    digit_select = 1'b0;
    segments     = enc(7'h7E);
    out_ready    = 1'b0;
    reset        = 1'b1;

    // 1: reset, out_ready pulses do nothing while idle
    step(2);
    chk("rst_value", out_value, 8'h00);
    chk("rst_valid", {7'b0, out_valid}, 8'h00);
    chk("rst_err", {7'b0, out_err}, 8'h00);
    chk("rst_overrun", {7'b0, overrun}, 8'h00);
    chk("rst_state", {6'b0, dbg_state}, 8'h00);
    reset = 1'b0;
    out_ready = 1'b1;
    step(3);
    out_ready = 1'b0;
    chk("idle_ready_valid", {7'b0, out_valid}, 8'h00);

    // 2: basic word with exact latency check
    drive(1'b0, 7'h5B, 4);
    chk("lo_to_s_hi", {6'b0, dbg_state}, 8'h01);
    drive(1'b1, 7'h30, 3);
    chk("hi_3cyc_no_valid", {7'b0, out_valid}, 8'h00);
    step(1);
    chk("hi_4cyc_valid", {7'b0, out_valid}, 8'h01);
    chk("basic_value", out_value, 8'h15);
    chk("basic_err", {7'b0, out_err}, 8'h00);
    handshake();
    chk("basic_accept", {7'b0, out_valid}, 8'h00);
    chk("basic_state_lo", {6'b0, dbg_state}, 8'h00);

    // 3: pattern alternating every 2 cycles never becomes stable
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, (i % 2 == 0) ? 7'h7E : 7'h30, 2);
    end
    chk("glitch_state", {6'b0, dbg_state}, 8'h00);
    chk("glitch_valid", {7'b0, out_valid}, 8'h00);

    // table-driven words (includes invalid and blank patterns)
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, vecs[i].lo_pat, 5);
      drive(1'b1, vecs[i].hi_pat, 5);
      chk($sformatf("vec%0d_valid", i), {7'b0, out_valid}, 8'h01);
      chk($sformatf("vec%0d_value", i), out_value, vecs[i].exp_value);
      chk($sformatf("vec%0d_err", i), {7'b0, out_err}, {7'b0, vecs[i].exp_err});
      handshake();
      chk($sformatf("vec%0d_accept", i), {7'b0, out_valid}, 8'h00);
    end
    chk("no_overrun_yet", {7'b0, overrun}, 8'h00);

    // lo re-latched while waiting in S_HI
    drive(1'b0, 7'h30, 5);
    drive(1'b0, 7'h5B, 5);
    drive(1'b1, 7'h7E, 5);
    chk("relatch_value", out_value, 8'h05);
    handshake();

    // a single stable window captures once only
    drive(1'b0, 7'h79, 12);
    chk("one_capture_state", {6'b0, dbg_state}, 8'h01);
    drive(1'b1, 7'h33, 5);
    chk("one_capture_value", out_value, 8'h43);

    // 5: overrun while holding a word
    drive(1'b0, 7'h7E, 5);
    chk("ovr_sticky", {7'b0, overrun}, 8'h01);
    chk("ovr_value_frozen", out_value, 8'h43);
    chk("ovr_valid_held", {7'b0, out_valid}, 8'h01);
    handshake();
    chk("ovr_accept_valid", {7'b0, out_valid}, 8'h00);
    chk("ovr_stays", {7'b0, overrun}, 8'h01);
    // dropped capture did not latch a lo digit
    chk("ovr_drop_state", {6'b0, dbg_state}, 8'h00);

    // capture and handshake on the same edge: handshake wins, capture dropped
    do_reset();
    drive(1'b0, 7'h30, 5);
    drive(1'b1, 7'h30, 5);
    chk("same_edge_pre_valid", {7'b0, out_valid}, 8'h01);
    drive(1'b0, 7'h6D, 3);
    out_ready = 1'b1;
    step(1);
    out_ready = 1'b0;
    chk("same_edge_valid", {7'b0, out_valid}, 8'h00);
    chk("same_edge_state", {6'b0, dbg_state}, 8'h00);
    chk("same_edge_overrun", {7'b0, overrun}, 8'h01);

    // 6: reset in S_HI discards the pending lo digit
    do_reset();
    chk("rst_clears_overrun", {7'b0, overrun}, 8'h00);
    drive(1'b0, 7'h7E, 5);
    chk("pre_rst_s_hi", {6'b0, dbg_state}, 8'h01);
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    drive(1'b1, 7'h79, 8);
    chk("rst_hi_only_valid", {7'b0, out_valid}, 8'h00);
    chk("rst_hi_only_state", {6'b0, dbg_state}, 8'h00);
    drive(1'b0, 7'h7E, 5);
    drive(1'b1, 7'h79, 5);
    chk("rst_recover_value", out_value, 8'h30);
    handshake();

    // raw bus patterns 01 / 4F: digits 0 and 1 on an active-low bus,
    // both unrecognised on an active-high bus
    digit_select = 1'b0;
    segments = 7'h01;
    step(5);
    digit_select = 1'b1;
    segments = 7'h4F;
    step(5);
`ifdef SSD_ACTIVE_LOW_EN
    chk("raw_value", out_value, 8'h10);
    chk("raw_err", {7'b0, out_err}, 8'h00);
`else
    chk("raw_value", out_value, 8'hFF);
    chk("raw_err", {7'b0, out_err}, 8'h01);
`endif
    handshake();

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
